evu_counter_bank: RTL and testbench

- Programmable hardware event-counter bank. It consumes the 1-bit outputs of the per-counter event multiplexers and drives their 4-bit select lines.
- Each counter has a control register (enable, event select, interrupt enable, sticky overflow) and a CNT_WIDTH count register.
- Registers are reached over a simple single-cycle request / one-cycle-ack register port from the CSR file.
- Sits beside the commit stage; overflow raises irq_o toward the interrupt controller.

---
 rtl/evu_counter_bank.sv | 154 +++++++++++++++
 tb/tb_evu_counter_bank.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/evu_counter_bank.sv
// Programmable event-counter bank: per-counter CTRL/COUNT registers behind a
// one-cycle-ack register port, with a one-stage event capture pipeline.

module evu_counter_lane #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 evt_i,
  input  logic                 inhibit_i,
  input  logic                 wr_ctrl_i,
  input  logic                 wr_cnt_i,
  input  logic [6:0]           ctrl_wdata_i,
  input  logic [CNT_WIDTH-1:0] cnt_wdata_i,
  output logic [3:0]           sel_o,
  output logic [31:0]          ctrl_o,
  output logic [31:0]          cnt_o,
  output logic                 irq_o
);
  logic                 en_q, en_d, ie_q, ie_d, ovf_q, ovf_d, evt_q, evt_d;
  logic [3:0]           sel_q, sel_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    en_d  = en_q;
    sel_d = sel_q;
    ie_d  = ie_q;
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    evt_d = evt_i & en_q & ~inhibit_i;
    if (wr_ctrl_i) begin
      en_d  = ctrl_wdata_i[0];
      sel_d = ctrl_wdata_i[4:1];
      ie_d  = ctrl_wdata_i[5];
      // the captured sample came through the old select, so drop it
      evt_d = 1'b0;
      if (ctrl_wdata_i[6]) ovf_d = 1'b0;
    end
    // a COUNT write swallows the pending increment and its overflow;
    // a wrap overrides a same-edge W1C of ovf
    if (wr_cnt_i) begin
      cnt_d = cnt_wdata_i;
    end else if (evt_q) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
      if (&cnt_q) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      en_q  <= 1'b0;
      sel_q <= '0;
      ie_q  <= 1'b0;
      ovf_q <= 1'b0;
      evt_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      en_q  <= en_d;
      sel_q <= sel_d;
      ie_q  <= ie_d;
      ovf_q <= ovf_d;
      evt_q <= evt_d;
      cnt_q <= cnt_d;
    end
  end

  assign sel_o  = sel_q;
  assign ctrl_o = {25'b0, ovf_q, ie_q, sel_q, en_q};
  assign cnt_o  = 32'(cnt_q);
  assign irq_o  = ovf_q & ie_q;
endmodule

module evu_counter_bank #(
  parameter int NUM_COUNTERS = 4,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_COUNTERS-1:0]   evt_i,
  output logic [4*NUM_COUNTERS-1:0] sel_o,
  input  logic                      inhibit_i,
  input  logic                      req_i,
  input  logic                      we_i,
  input  logic [3:0]                addr_i,
  input  logic [31:0]               wdata_i,
  output logic                      ack_o,
  output logic [31:0]               rdata_o,
  output logic                      err_o,
  output logic                      irq_o
);
  logic [NUM_COUNTERS-1:0][31:0] ctrl_rd, cnt_rd;
  logic [NUM_COUNTERS-1:0]       irq_v;
  logic [2:0]                    idx;
  logic                          idx_err;
  logic [31:0]                   rd_val;
  logic                          ack_q, ack_d, err_q, err_d;
  logic [31:0]                   rdata_q, rdata_d;

  assign idx     = addr_i[3:1];
  assign idx_err = {1'b0, idx} >= 4'(NUM_COUNTERS);

  for (genvar k = 0; k < NUM_COUNTERS; k++) begin : g_lane
    logic sel_hit;
    assign sel_hit = req_i & we_i & (idx == 3'(k));
    evu_counter_lane #(.CNT_WIDTH(CNT_WIDTH)) u_lane (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .evt_i       (evt_i[k]),
      .inhibit_i   (inhibit_i),
      .wr_ctrl_i   (sel_hit & ~addr_i[0]),
      .wr_cnt_i    (sel_hit & addr_i[0]),
      .ctrl_wdata_i(wdata_i[6:0]),
      .cnt_wdata_i (wdata_i[CNT_WIDTH-1:0]),
      .sel_o       (sel_o[4*k +: 4]),
      .ctrl_o      (ctrl_rd[k]),
      .cnt_o       (cnt_rd[k]),
      .irq_o       (irq_v[k])
    );
  end

  always_comb begin
    rd_val = '0;
    for (int k = 0; k < NUM_COUNTERS; k++)
      if (idx == 3'(k)) rd_val = addr_i[0] ? cnt_rd[k] : ctrl_rd[k];
  end

  // read data and error are captured per request and held between acks
  always_comb begin
    ack_d   = req_i;
    err_d   = err_q;
    rdata_d = rdata_q;
    if (req_i) begin
      err_d   = idx_err;
      rdata_d = (we_i || idx_err) ? 32'h0 : rd_val;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign ack_o   = ack_q;
  assign err_o   = err_q;
  assign rdata_o = (ack_q && !err_q) ? rdata_q : 32'h0;
  assign irq_o   = |irq_v;
endmodule

// File: tb/tb_evu_counter_bank.sv
// Directed bench for evu_counter_bank: a vector table for register/count
// behaviour plus hand sequences for collisions, inhibit and async reset.

module tb_evu_counter_bank;
  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   evt = '0;
  logic [4*N-1:0] sel;
  logic           inh = 1'b0, req = 1'b0, we = 1'b0;
  logic [3:0]     addr = '0;
  logic [31:0]    wdata = '0, rdata;
  logic           ack, err, irq;
  int             n_vec = 0, n_bad = 0;

  evu_counter_bank #(.NUM_COUNTERS(N), .CNT_WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst), .evt_i(evt), .sel_o(sel), .inhibit_i(inh),
    .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .ack_o(ack), .rdata_o(rdata), .err_o(err), .irq_o(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req, we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  evt;
    logic        chk_rd;
    logic        ack;
    logic [31:0] rdata;
    logic        err, irq;
    logic [15:0] sel;
  } vec_t;
  vec_t tv[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic r, input logic w, input logic [3:0] a, input logic [31:0] d);
    req = r; we = w; addr = a; wdata = d;
  endtask

  initial begin
    //                req we addr  wdata         evt     rd ack rdata         err irq sel
    tv.push_back(vec_t'{1, 0, 4'h0, 32'h0,         4'b0000, 1, 1, 32'h0,         0, 0, 16'h0});
    tv.push_back(vec_t'{1, 0, 4'h1, 32'h0,         4'b0000, 1, 1, 32'h0,         0, 0, 16'h0});
    tv.push_back(vec_t'{0, 0, 4'h0, 32'h0,         4'b0000, 1, 0, 32'h0,         0, 0, 16'h0});
    tv.push_back(vec_t'{1, 1, 4'h0, 32'h25,        4'b0000, 0, 1, 32'h0,         0, 0, 16'h2});
    tv.push_back(vec_t'{1, 0, 4'h1, 32'h0,         4'b0001, 1, 1, 32'h0,         0, 0, 16'h2});
    tv.push_back(vec_t'{1, 0, 4'h1, 32'h0,         4'b0000, 1, 1, 32'h0,         0, 0, 16'h2});
    tv.push_back(vec_t'{1, 0, 4'h1, 32'h0,         4'b0001, 1, 1, 32'h1,         0, 0, 16'h2});
    tv.push_back(vec_t'{1, 0, 4'h1, 32'h0,         4'b0000, 1, 1, 32'h1,         0, 0, 16'h2});
    tv.push_back(vec_t'{1, 0, 4'h1, 32'h0,         4'b0001, 1, 1, 32'h2,         0, 0, 16'h2});
    tv.push_back(vec_t'{1, 0, 4'h1, 32'h0,         4'b0000, 1, 1, 32'h2,         0, 0, 16'h2});
    tv.push_back(vec_t'{1, 0, 4'h1, 32'h0,         4'b0000, 1, 1, 32'h3,         0, 0, 16'h2});
    tv.push_back(vec_t'{1, 1, 4'h1, 32'hFFFF_FFFE, 4'b0000, 0, 1, 32'h0,         0, 0, 16'h2});
    tv.push_back(vec_t'{0, 0, 4'h0, 32'h0,         4'b0001, 0, 0, 32'h0,         0, 0, 16'h2});
    tv.push_back(vec_t'{0, 0, 4'h0, 32'h0,         4'b0001, 0, 0, 32'h0,         0, 0, 16'h2});
    tv.push_back(vec_t'{0, 0, 4'h0, 32'h0,         4'b0000, 0, 0, 32'h0,         0, 1, 16'h2});
    tv.push_back(vec_t'{1, 0, 4'h1, 32'h0,         4'b0000, 1, 1, 32'h0,         0, 1, 16'h2});
    tv.push_back(vec_t'{1, 0, 4'h0, 32'h0,         4'b0000, 1, 1, 32'h65,        0, 1, 16'h2});
    tv.push_back(vec_t'{1, 1, 4'h0, 32'h65,        4'b0000, 0, 1, 32'h0,         0, 0, 16'h2});
    tv.push_back(vec_t'{1, 0, 4'h0, 32'h0,         4'b0000, 1, 1, 32'h25,        0, 0, 16'h2});
    tv.push_back(vec_t'{1, 0, 4'hA, 32'h0,         4'b0000, 1, 1, 32'h0,         1, 0, 16'h2});
    tv.push_back(vec_t'{1, 1, 4'hA, 32'hFFFF_FFFF, 4'b0000, 1, 1, 32'h0,         1, 0, 16'h2});
    tv.push_back(vec_t'{1, 0, 4'h0, 32'h0,         4'b0000, 1, 1, 32'h25,        0, 0, 16'h2});
    tv.push_back(vec_t'{1, 0, 4'h1, 32'h0,         4'b0000, 1, 1, 32'h0,         0, 0, 16'h2});
    tv.push_back(vec_t'{1, 0, 4'h6, 32'h0,         4'b0000, 1, 1, 32'h0,         0, 0, 16'h2});
    tv.push_back(vec_t'{1, 0, 4'h8, 32'h0,         4'b0000, 1, 1, 32'h0,         1, 0, 16'h2});
    tv.push_back(vec_t'{1, 1, 4'h4, 32'h21,        4'b0000, 0, 1, 32'h0,         0, 0, 16'h2});
    tv.push_back(vec_t'{1, 1, 4'h5, 32'hFFFF_FFFF, 4'b0000, 0, 1, 32'h0,         0, 0, 16'h2});
    tv.push_back(vec_t'{0, 0, 4'h0, 32'h0,         4'b0100, 0, 0, 32'h0,         0, 0, 16'h2});
    tv.push_back(vec_t'{1, 1, 4'h4, 32'h61,        4'b0000, 0, 1, 32'h0,         0, 1, 16'h2});
    tv.push_back(vec_t'{1, 0, 4'h4, 32'h0,         4'b0000, 1, 1, 32'h61,        0, 1, 16'h2});
    tv.push_back(vec_t'{1, 0, 4'h5, 32'h0,         4'b0000, 1, 1, 32'h0,         0, 1, 16'h2});
    tv.push_back(vec_t'{1, 1, 4'h4, 32'h40,        4'b0000, 0, 1, 32'h0,         0, 0, 16'h2});
    tv.push_back(vec_t'{1, 0, 4'h4, 32'h0,         4'b0000, 1, 1, 32'h0,         0, 0, 16'h2});

    step; step;
    chk("reset ack", {31'b0, ack}, 32'h0);
    chk("reset rdata", rdata, 32'h0);
    chk("reset err", {31'b0, err}, 32'h0);
    chk("reset sel", {16'b0, sel}, 32'h0);
    chk("reset irq", {31'b0, irq}, 32'h0);
    rst = 1'b0;
    step;

    for (int i = 0; i < tv.size(); i++) begin
      set_req(tv[i].req, tv[i].we, tv[i].addr, tv[i].wdata);
      evt = tv[i].evt;
      step;
      chk($sformatf("v%0d ack", i), {31'b0, ack}, {31'b0, tv[i].ack});
      if (tv[i].ack) chk($sformatf("v%0d err", i), {31'b0, err}, {31'b0, tv[i].err});
      if (tv[i].chk_rd) chk($sformatf("v%0d rdata", i), rdata, tv[i].rdata);
      chk($sformatf("v%0d irq", i), {31'b0, irq}, {31'b0, tv[i].irq});
      chk($sformatf("v%0d sel", i), {16'b0, sel}, {16'b0, tv[i].sel});
    end

    // counter 1: COUNT write beats an in-flight increment
    set_req(1, 1, 4'h2, 32'h1); evt = '0;
    step;
    set_req(0, 0, 4'h0, 32'h0); evt[1] = 1'b1;
    step; step;
    set_req(1, 1, 4'h3, 32'h10);
    step;
    set_req(1, 0, 4'h3, 32'h0);
    step; chk("coll write wins", rdata, 32'h10);
    step; chk("coll next inc", rdata, 32'h11);

    // inhibit: one in-flight increment, then stall, resume two edges later
    inh = 1'b1;
    step; chk("inh c0", rdata, 32'h12);
    for (int i = 0; i < 4; i++) begin
      step; chk($sformatf("inh stall %0d", i), rdata, 32'h13);
    end
    inh = 1'b0;
    step; chk("inh fall e1", rdata, 32'h13);
    step; chk("inh fall e2", rdata, 32'h13);
    step; chk("inh resumed", rdata, 32'h14);

    // async reset with an ack pending and counting active
    #2 rst = 1'b1;
    #1;
    chk("async rst ack", {31'b0, ack}, 32'h0);
    chk("async rst rdata", rdata, 32'h0);
    chk("async rst sel", {16'b0, sel}, 32'h0);
    chk("async rst irq", {31'b0, irq}, 32'h0);
    set_req(0, 0, 4'h0, 32'h0);
    step;
    rst = 1'b0;
    set_req(1, 0, 4'h3, 32'h0);
    step; chk("post rst cnt1", rdata, 32'h0);
    chk("post rst ack", {31'b0, ack}, 32'h1);
    set_req(1, 0, 4'h0, 32'h0);
    step; chk("post rst ctrl0", rdata, 32'h0);
    set_req(0, 0, 4'h0, 32'h0);
    step; chk("post rst idle ack", {31'b0, ack}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
